gshare_branch_predictor: RTL
============================

// Module: gshare_branch_predictor
// PURPOSE
//  Parametrised gshare direction predictor that supersedes the per-PC bimodal BHT.
//  Indexes a table of saturating counters (PHT) with PC XOR a speculative global history
//  register (GHR). Fetch/decode looks it up combinationally; execute trains it and repairs the GHR.
//  Sits beside the PC-select logic in the pipelined core.
// PARAMETERS
//  PC_W    8  width of lookup/update PC fields
//  IDX_W   8  PHT index width; PHT depth = 2**IDX_W
//  HIST_W  8  GHR width; legal range 1..IDX_W
//  CTR_W   2  saturating counter width; legal range >= 1
// PORTS
//  clk            in   1       clock, rising edge
//  reset          in   1       asynchronous, active-high
//  lookup_valid   in   1       branch is being predicted this cycle
//  lookup_pc      in   PC_W    PC of the predicted branch
//  pred_taken     out  1       predicted direction (combinational)
//  pred_hist      out  HIST_W  GHR used for this prediction; carried down the pipe
//  upd_valid      in   1       resolved branch training request
//  upd_pc         in   PC_W    PC of the resolved branch
//  upd_hist       in   HIST_W  pred_hist captured at lookup time
//  upd_taken      in   1       actual outcome
//  upd_mispredict in   1       outcome differed from prediction; qualified by upd_valid
// BEHAVIOUR
//  - Index: lk_idx = lookup_pc[IDX_W-1:0] ^ {0, GHR}; up_idx = upd_pc[IDX_W-1:0] ^ {0, upd_hist}.
//    Zero-extend HIST_W to IDX_W. Use the PC low bits; zero-extend if PC_W < IDX_W.
//  - pred_taken = MSB of PHT[lk_idx]. pred_hist = current GHR. Both are pure combinational,
//    zero latency, and valid regardless of lookup_valid.
//  - Training, when upd_valid: PHT[up_idx] <= sat(+1) if upd_taken, else sat(-1).
//    Saturate at 2**CTR_W-1 and at 0. No wrap-around. Single RMW per cycle.
//  - GHR update on the clock edge, in priority order:
//    1. upd_valid & upd_mispredict: GHR <= {upd_hist[HIST_W-2:0], upd_taken}.
//       When HIST_W=1, GHR <= upd_taken. Any simultaneous lookup is flushed; its shift is dropped.
//    2. else lookup_valid: GHR <= {GHR[HIST_W-2:0], pred_taken} (speculative).
//    3. else GHR holds its value.
//  - A correctly predicted update does not touch the GHR.
//  - Reset (asynchronous, any time, including mid-training):
//    GHR <= 0; every PHT entry <= 2**(CTR_W-1)-1 (weakly not-taken; 01 for CTR_W=2).
//    pred_taken reads 0 and pred_hist reads 0 while reset is asserted and after it.
//  - Update and lookup on the same index in the same cycle: the lookup sees the pre-update
//    counter unless forwarding is compiled in (see CONFIGURATION).
// CONFIGURATION
//  BPU_UPDATE_FWD_EN defined: if upd_valid and up_idx == lk_idx, pred_taken uses the
//    post-update counter value computed this cycle (write-to-read bypass).
//  Undefined: no bypass; pred_taken reflects only the registered PHT contents.
//  Ports and reset behaviour are identical in both builds.
// STRUCTURE
//  - bpu_pkg: CTR_W-generic function sat_ctr_next(ctr, taken); localparam CTR_INIT;
//    hist_shift function shared with future tournament/BTB blocks.
//  - Sub-module bpu_pht: 2**IDX_W x CTR_W array with async reset, one combinational read port
//    and one RMW write port.
//  - Top level holds the GHR, the index hashing and the forwarding mux.
// TESTING (defaults: PC_W=IDX_W=HIST_W=8, CTR_W=2)
//  1. Reset, then lookup_pc=0x00 -> pred_taken=0, pred_hist=0x00.
//     Idle 5 cycles -> GHR stays 0x00.
//  2. Three updates at pc=0x10, hist=0x00, taken=1 -> counter 01->10->11->11 (saturates).
//     Lookup pc=0x10 with GHR=0 -> taken=1. One not-taken update -> 10, still taken=1.
//  3. GHR=0x00, lookup_valid with a predicted-taken entry -> next cycle GHR=0x01.
//     pred_hist reported 0x00 for that lookup. A second taken lookup -> GHR=0x03.
//  4. GHR=0x03, same cycle lookup_valid=1 and update mispredict (hist=0x05, taken=0)
//     -> GHR=0x0A. The lookup shift is discarded.
//  5. Assert reset mid-train (after 1 of 3 taken updates at pc=0x20)
//     -> counter back to 01 and GHR=0. The next lookup at pc=0x20 gives 0.
//  6. Same-cycle update (taken, counter 01) and lookup on the same index
//     -> pred_taken=1 with BPU_UPDATE_FWD_EN, 0 without it. Taken=1 in both builds next cycle.

Source files
------------

// File: rtl/bpu_pkg.sv
// Shared branch-prediction helpers: width-generic saturating counter, history shift, counter init value.
package bpu_pkg;

    function automatic logic [31:0] ctr_init_value(input int unsigned ctr_w);
        return (32'd1 << (ctr_w - 1)) - 32'd1;
    endfunction

    localparam int unsigned CTR_W_DEFAULT = 2;
    localparam logic [31:0] CTR_INIT      = ctr_init_value(CTR_W_DEFAULT);

    // Counters narrower than 32 bits are passed zero-extended; the caller truncates the result.
    function automatic logic [31:0] sat_ctr_next(input logic [31:0] ctr,
                                                 input logic        taken,
                                                 input int unsigned ctr_w);
        logic [31:0] max_val;
        max_val = (ctr_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << ctr_w) - 32'd1);
        if (taken) begin
            return (ctr >= max_val) ? max_val : ctr + 32'd1;
        end
        return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
    endfunction

    function automatic logic [31:0] hist_shift(input logic [31:0] hist,
                                               input logic        bit_in,
                                               input int unsigned hist_w);
        logic [31:0] shifted;
        logic [31:0] mask;
        shifted = {hist[30:0], bit_in};
        mask    = (hist_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << hist_w) - 32'd1);
        return shifted & mask;
    endfunction

endpackage

// File: rtl/bpu_pht.sv
// Pattern history table: 2**IDX_W saturating counters, one combinational read port, one RMW port.
module bpu_pht
    import bpu_pkg::*;
#(
    parameter int IDX_W = 8,
    parameter int CTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CTR_W-1:0] rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken,
    output logic [CTR_W-1:0] wr_ctr_next
);

    localparam int DEPTH = 2 ** IDX_W;
    localparam logic [CTR_W-1:0] INIT_VAL = CTR_W'(ctr_init_value(CTR_W));

    logic [CTR_W-1:0] ctr_reg [DEPTH];

    // Exposed so the top can bypass the value being written this cycle.
    assign wr_ctr_next = CTR_W'(sat_ctr_next(32'(ctr_reg[wr_idx]), wr_taken, CTR_W));
    assign rd_ctr      = ctr_reg[rd_idx];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    ctr_reg[gi] <= INIT_VAL;
                end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
                    ctr_reg[gi] <= wr_ctr_next;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/gshare_branch_predictor.sv
// gshare direction predictor: PC xor speculative GHR indexes the PHT; execute trains and repairs.
// Optional write-to-read bypass when BPU_UPDATE_FWD_EN is defined.
module gshare_branch_predictor
    import bpu_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int IDX_W  = 8,
    parameter int HIST_W = 8,
    parameter int CTR_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lookup_valid,
    input  logic [PC_W-1:0]   lookup_pc,
    output logic              pred_taken,
    output logic [HIST_W-1:0] pred_hist,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic [HIST_W-1:0] upd_hist,
    input  logic              upd_taken,
    input  logic              upd_mispredict
);

    logic [HIST_W-1:0] ghr_reg;
    logic [HIST_W-1:0] ghr_next;
    logic [IDX_W-1:0]  lk_pc_bits;
    logic [IDX_W-1:0]  up_pc_bits;
    logic [IDX_W-1:0]  lk_idx;
    logic [IDX_W-1:0]  up_idx;
    logic [CTR_W-1:0]  rd_ctr;
    logic [CTR_W-1:0]  wr_ctr_next;
    logic [CTR_W-1:0]  pred_ctr;

    generate
        if (PC_W >= IDX_W) begin : g_pc_trunc
            assign lk_pc_bits = lookup_pc[IDX_W-1:0];
            assign up_pc_bits = upd_pc[IDX_W-1:0];
            if (PC_W > IDX_W) begin : g_pc_hi
                logic unused_pc_hi;
                assign unused_pc_hi = ^{lookup_pc[PC_W-1:IDX_W], upd_pc[PC_W-1:IDX_W]};
            end
        end else begin : g_pc_ext
            assign lk_pc_bits = IDX_W'(lookup_pc);
            assign up_pc_bits = IDX_W'(upd_pc);
        end
    endgenerate

    assign lk_idx = lk_pc_bits ^ IDX_W'(ghr_reg);
    assign up_idx = up_pc_bits ^ IDX_W'(upd_hist);

    bpu_pht #(
        .IDX_W(IDX_W),
        .CTR_W(CTR_W)
    ) u_pht (
        .clk        (clk),
        .reset      (reset),
        .rd_idx     (lk_idx),
        .rd_ctr     (rd_ctr),
        .wr_en      (upd_valid),
        .wr_idx     (up_idx),
        .wr_taken   (upd_taken),
        .wr_ctr_next(wr_ctr_next)
    );

`ifdef BPU_UPDATE_FWD_EN
    assign pred_ctr = (upd_valid && (up_idx == lk_idx)) ? wr_ctr_next : rd_ctr;
`else
    assign pred_ctr = rd_ctr;
`endif

    // Gated so a bypassed update cannot leak a taken prediction while reset is held.
    assign pred_taken = pred_ctr[CTR_W-1] & ~reset;
    assign pred_hist  = ghr_reg;

    // A mispredict repair overrides (flushes) any speculative shift from this cycle's lookup.
    always_comb begin
        ghr_next = ghr_reg;
        if (upd_valid && upd_mispredict) begin
            ghr_next = HIST_W'(hist_shift(32'(upd_hist), upd_taken, HIST_W));
        end else if (lookup_valid) begin
            ghr_next = HIST_W'(hist_shift(32'(ghr_reg), pred_taken, HIST_W));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ghr_reg <= '0;
        end else begin
            ghr_reg <= ghr_next;
        end
    end

endmodule
